// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan -- multiplexed 4-digit 7-segment scan controller
//
// Feeds a 2-to-4 active-low digit decoder (dig_sel, dig_off) and drives the
// shared active-low segment bus. A 16-bit hex value plus four decimal points
// are snapshotted once per frame. The controller then rotates through the
// digits at a fixed slot rate. Each slot starts with a blanking gap so that
// a digit change never shows on a lit digit.
//
// Parameters:
//   CLK_HZ     input clock frequency in Hz
//   SCAN_HZ    digit slot rate in Hz; DIV = CLK_HZ/SCAN_HZ cycles per slot (>= 2)
//   BLANK_CYC  cycles dark at the start of each slot (0 <= BLANK_CYC < DIV)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          display enable; 0 darkens all digits, scanning continues
//   data[15:0]  four hex digits, digit n = data[4n+3:4n], digit 0 rightmost
//   dp[3:0]     decimal points, dp[n]=1 lights the point of digit n
//   dig_sel     digit index to the decoder
//   dig_off     1 = all digits off (decoder enable)
//   seg[7:0]    active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick  one-cycle pulse on the edge that takes the snapshot
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a digit 3..1 is suppressed while it
//                          and every higher nibble of the snapshot are zero.
// ---------------------------------------------------------------------------
module seg_scan #(
    parameter int CLK_HZ    = 50000000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    output logic [1:0]  dig_sel,
    output logic        dig_off,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q,       cnt_d;
    logic [1:0]    dig_sel_q,   dig_sel_d;
    logic          dig_off_q,   dig_off_d;
    logic [7:0]    seg_q,       seg_d;
    logic          frame_q,     frame_d;
    logic [15:0]   snap_data_q, snap_data_d;
    logic [3:0]    snap_dp_q,   snap_dp_d;

    logic          slot_end;
    logic          in_blank;
    logic [3:0]    nib;
    logic [7:0]    seg_pat;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Blanking window is judged on the count the slot will hold after the
    // edge, so dig_off is already high on the edge that changes the digit.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYC);
            assign in_blank = (cnt_d < BLANK_W);
        end
    endgenerate

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value held and no latch is inferred.
    always_comb begin
        slot_end    = (cnt_q == CNT_MAX);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        dig_sel_d   = dig_sel_q + {1'b0, slot_end};
        frame_d     = slot_end && (dig_sel_q == 2'd3);
        snap_data_d = frame_d ? data : snap_data_q;
        snap_dp_d   = frame_d ? dp   : snap_dp_q;

        // Pattern comes from the next-state snapshot, so digit 0 of a new
        // frame shows the value captured on that same edge.
        nib     = snap_data_d[{dig_sel_d, 2'b00} +: 4];
        seg_pat = {~snap_dp_d[dig_sel_d], hex_to_seg(nib)};
`ifdef LEADING_ZERO_BLANK_EN
        case (dig_sel_d)
            2'd3:    if (snap_data_d[15:12] == 4'h0)  seg_pat[6:0] = 7'h7F;
            2'd2:    if (snap_data_d[15:8]  == 8'h00) seg_pat[6:0] = 7'h7F;
            2'd1:    if (snap_data_d[15:4]  == 12'h0) seg_pat[6:0] = 7'h7F;
            default: ;
        endcase
`endif
        seg_d     = slot_end ? seg_pat : seg_q;
        dig_off_d = !en || in_blank;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= CNT_MAX;
            dig_sel_q   <= 2'd3;
            dig_off_q   <= 1'b1;
            seg_q       <= 8'hFF;
            frame_q     <= 1'b0;
            snap_data_q <= '0;
            snap_dp_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            dig_sel_q   <= dig_sel_d;
            dig_off_q   <= dig_off_d;
            seg_q       <= seg_d;
            frame_q     <= frame_d;
            snap_data_q <= snap_data_d;
            snap_dp_q   <= snap_dp_d;
        end
    end

    assign dig_sel    = dig_sel_q;
    assign dig_off    = dig_off_q;
    assign seg        = seg_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan -- self-checking bench for seg_scan (DIV = 10, BLANK_CYC = 2)
//
// The reference model counts edges since reset release and derives slot,
// digit, blanking and frame start with plain arithmetic. It keeps its own
// copy of the per-frame snapshot and looks glyphs up in a table.
// ---------------------------------------------------------------------------
module tb_seg_scan;

    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int BLANK_CYC = 2;
    localparam int DIV       = CLK_HZ / SCAN_HZ;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [1:0]  dig_sel;
    logic        dig_off;
    logic [7:0]  seg;
    logic        frame_tick;

    seg_scan #(
        .CLK_HZ    (CLK_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .dig_off    (dig_off),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int          n_cmp = 0;
    int          n_mis = 0;
    int          k = 0;          // edges since reset release
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    // One clock edge: capture the inputs the DUT sees, advance, then compare
    // every output with the model's expectation.
    task automatic step();
        logic        en_s;
        logic [15:0] d_s;
        logic [3:0]  dp_s;
        int          p, sel, nibv;
        logic        tick;
        logic [7:0]  e;
        en_s = en; d_s = data; dp_s = dp;
        @(posedge clk); #1;
        k++;
        p    = (k - 1) % DIV;
        sel  = ((k - 1) / DIV) % 4;
        tick = ((k - 1) % (4 * DIV)) == 0;
        if (tick) begin
            m_data = d_s;
            m_dp   = dp_s;
        end
        nibv = int'((m_data >> (4 * sel)) & 16'hF);
        e    = hex_tab[nibv];
        e[7] = ~m_dp[sel];
`ifdef LEADING_ZERO_BLANK_EN
        if (sel != 0 && (m_data >> (4 * sel)) == 16'h0) e[6:0] = 7'h7F;
`endif
        chk("frame_tick", {15'h0, frame_tick}, {15'h0, tick});
        chk("dig_sel",    {14'h0, dig_sel},    {14'h0, sel[1:0]});
        chk("dig_off",    {15'h0, dig_off},    {15'h0, (!en_s || p < BLANK_CYC)});
        chk("seg",        {8'h0, seg},         {8'h0, e});
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dig_off"}, {15'h0, dig_off},    16'h1);
        chk({tag, "_seg"},     {8'h0, seg},         16'hFF);
        chk({tag, "_tick"},    {15'h0, frame_tick}, 16'h0);
        chk({tag, "_dig_sel"}, {14'h0, dig_sel},    16'h3);
    endtask

    initial begin
        // Reset hold
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("rst_async");
        repeat (2) begin
            @(posedge clk); #1;
            chk_reset_vals("rst_hold");
        end
        data = 16'h1234; dp = 4'h0; en = 1'b1;
        rst_n = 1'b1;
        k = 0;

        // First frame after release
        run_to(1);
        chk("first_seg",  {8'h0, seg},         16'h0099);
        chk("first_tick", {15'h0, frame_tick}, 16'h1);
        chk("first_sel",  {14'h0, dig_sel},    16'h0);
        chk("first_off",  {15'h0, dig_off},    16'h1);
        run_to(3);
        chk("lit_after_blank", {15'h0, dig_off}, 16'h0);

        // Mid-frame data change stays invisible until the next frame
        run_to(12);
        data = 16'hABCD;
        run_to(25);
        chk("no_tear_d2", {8'h0, seg}, 16'h00A4);
        run_to(35);
        chk("no_tear_d3", {8'h0, seg}, 16'h00F9);
        run_to(75);
        chk("new_frame_d3", {8'h0, seg}, 16'h0088);
        run_to(80);

        // All zeros with a decimal point on digit 0
        data = 16'h0000; dp = 4'b0001;
        run_to(83);
        chk("zero_dp_d0", {8'h0, seg}, 16'h0040);
        run_to(93);
`ifdef LEADING_ZERO_BLANK_EN
        chk("zero_d1", {8'h0, seg}, 16'h00FF);
`else
        chk("zero_d1", {8'h0, seg}, 16'h00C0);
`endif
        run_to(120);

        // Display disabled mid-frame for 25 cycles
        data = 16'h5A0F; dp = 4'b0100;
        run_to(125);
        en = 1'b0;
        run_to(150);
        en = 1'b1;
        run_to(200);

        // Randomized stretch
        repeat (400) begin
            if ($urandom_range(9) == 0) begin
                data = 16'($urandom);
                dp   = 4'($urandom);
            end
            if ($urandom_range(15) == 0) data = 16'h0;
            en = ($urandom_range(7) != 0);
            step();
        end

        // Asynchronous reset mid-slot, away from any clock edge
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_mid");
        @(posedge clk); #1;
        chk_reset_vals("rst_mid_hold");
        data = 16'h1234; dp = 4'h0; en = 1'b1;
        rst_n = 1'b1;
        k = 0;
        run_to(1);
        chk("recover_seg", {8'h0, seg}, 16'h0099);
        run_to(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
